// File: rtl/if_id_fetch_buffer_if.sv
// ---------------------------------------------------------------------------
// if_id_fetch_buffer_if
//
// Purpose:
//   Bundles the fetch-side push port and the decode-side pop port of the
//   IF/ID fetch buffer.
//
// Signals:
//   if_pc          fetch -> buffer   pc of the fetched instruction
//   if_instruction fetch -> buffer   fetched instruction word
//   if_valid       fetch -> buffer   fetch presents a valid pair
//   in_ready       buffer -> fetch   buffer accepts a push (fetch PC_write)
//   flush          ctrl  -> buffer   discard every buffered entry
//   id_pc          buffer -> decode  head entry pc
//   id_instruction buffer -> decode  head entry instruction (NOP when empty)
//   id_valid       buffer -> decode  head entry valid
//   id_ready       decode -> buffer  decode consumes the head this cycle
//   count          buffer -> any     current occupancy
//
// Modports:
//   master  the surrounding pipeline (fetch, decode, redirect control)
//   slave   the buffer itself
// ---------------------------------------------------------------------------
interface if_id_fetch_buffer_if #(
    parameter int PC_W  = 32,
    parameter int DEPTH = 2
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic [PC_W-1:0]  if_pc;
    logic [31:0]      if_instruction;
    logic             if_valid;
    logic             in_ready;
    logic             flush;
    logic [PC_W-1:0]  id_pc;
    logic [31:0]      id_instruction;
    logic             id_valid;
    logic             id_ready;
    logic [CNT_W-1:0] count;

    modport master (
        output if_pc, if_instruction, if_valid, flush, id_ready,
        input  in_ready, id_pc, id_instruction, id_valid, count
    );

    modport slave (
        input  if_pc, if_instruction, if_valid, flush, id_ready,
        output in_ready, id_pc, id_instruction, id_valid, count
    );
endinterface

// File: rtl/if_id_fetch_buffer.sv
// ---------------------------------------------------------------------------
// if_id_fetch_buffer
//
// Purpose:
//   IF/ID boundary buffer sitting right after instruction fetch. Fetched
//   {pc, instruction} pairs are queued in a small FIFO and handed to decode
//   through a valid/ready handshake. in_ready is fed back to fetch as its
//   PC_write enable. A branch flush empties the buffer, after which decode
//   sees a NOP bubble.
//
// Parameters:
//   DEPTH      number of entries (power of two, >= 2)
//   PC_W       pc width
//   NOP_INSTR  instruction presented while id_valid is low
//
// Ports:
//   clk   rising-edge clock
//   rst   asynchronous reset, active-low
//   bus   if_id_fetch_buffer_if.slave (fetch push side, decode pop side,
//         flush and occupancy)
// ---------------------------------------------------------------------------
module if_id_fetch_buffer #(
    parameter int          DEPTH     = 2,
    parameter int          PC_W      = 32,
    parameter logic [31:0] NOP_INSTR = 32'h00000013
) (
    input  logic                  clk,
    input  logic                  rst,
    if_id_fetch_buffer_if.slave   bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [PC_W-1:0]  pcMem_q    [DEPTH];
    logic [31:0]      instrMem_q [DEPTH];

    logic [PTR_W-1:0] wrPtr_q, wrPtr_d;
    logic [PTR_W-1:0] rdPtr_q, rdPtr_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic inReady;
    logic idValid;
    logic push;
    logic pop;

    // in_ready depends only on reset and registered occupancy, so there is
    // no combinational path from id_ready back to fetch. A pop while full
    // therefore only frees the slot for the following cycle.
    assign inReady = rst & (count_q < CNT_W'(DEPTH));
    assign idValid = (count_q != '0);
    assign push    = bus.if_valid & inReady;
    assign pop     = idValid & bus.id_ready;

    // Flush wins over any push or pop in the same cycle; pointers wrap
    // naturally because DEPTH is a power of two.
    always_comb begin
        wrPtr_d = wrPtr_q;
        rdPtr_d = rdPtr_q;
        count_d = count_q;
        if (bus.flush) begin
            wrPtr_d = '0;
            rdPtr_d = '0;
            count_d = '0;
        end else begin
            if (push) begin
                wrPtr_d = wrPtr_q + PTR_W'(1);
            end
            if (pop) begin
                rdPtr_d = rdPtr_q + PTR_W'(1);
            end
            count_d = count_q + CNT_W'(push) - CNT_W'(pop);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
        end else begin
            wrPtr_q <= wrPtr_d;
            rdPtr_q <= rdPtr_d;
            count_q <= count_d;
        end
    end

    // Storage needs no reset: an entry is only ever read once count covers it.
    // A push coinciding with a flush is dropped; fetch refetches it after the
    // redirect.
    always_ff @(posedge clk) begin
        if (push && !bus.flush) begin
            pcMem_q[wrPtr_q]    <= bus.if_pc;
            instrMem_q[wrPtr_q] <= bus.if_instruction;
        end
    end

    // Head is read straight from storage; there is deliberately no bypass
    // from if_* so a push is visible on id_* one cycle later at the earliest.
    assign bus.in_ready       = inReady;
    assign bus.id_valid       = idValid;
    assign bus.id_pc          = idValid ? pcMem_q[rdPtr_q] : '0;
    assign bus.id_instruction = idValid ? instrMem_q[rdPtr_q] : NOP_INSTR;
    assign bus.count          = count_q;
endmodule
